// File: rtl/mem_load_ctrl.sv
// Host-stream loader: decodes command headers, writes inst/data memory word pairs and
// sequences the core through load/halt/run. Define LOAD_CHECKSUM_EN for the trailing checksum word.
module mem_load_ctrl #(
   parameter int ADDR_W    = 9,
   parameter int ADDR_STEP = 8,
   parameter int CNT_W     = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [ADDR_W-1:0] inst_addr,
   output logic [31:0]       inst_data1,
   output logic [31:0]       inst_data2,
   output logic              inst_we,
   output logic [ADDR_W-1:0] data_addr,
   output logic [31:0]       data_data1,
   output logic [31:0]       data_data2,
   output logic              data_we,
   output logic              core_load,
   output logic              core_halt,
   output logic              busy,
   output logic              err,
   output logic [CNT_W-1:0]  words_done
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_GET_LO = 3'd1;
   localparam logic [2:0] S_GET_HI = 3'd2;
   localparam logic [2:0] S_COMMIT = 3'd3;
`ifdef LOAD_CHECKSUM_EN
   localparam logic [2:0] S_CHECK  = 3'd4;
`endif
   localparam logic [2:0] S_RUN    = 3'd5;

   localparam logic [1:0] CMD_INST = 2'b00;
   localparam logic [1:0] CMD_DATA = 2'b01;
   localparam logic [1:0] CMD_RUN  = 2'b10;

   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

   logic [2:0]        state_q, state_d;
   logic              tgt_q, tgt_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  words_done_q, words_done_d;
   logic [ADDR_W-1:0] inst_addr_q, inst_addr_d;
   logic [31:0]       inst_data1_q, inst_data1_d;
   logic [31:0]       inst_data2_q, inst_data2_d;
   logic [ADDR_W-1:0] data_addr_q, data_addr_d;
   logic [31:0]       data_data1_q, data_data1_d;
   logic [31:0]       data_data2_q, data_data2_d;
   logic              core_load_q, core_load_d;
   logic              core_halt_q, core_halt_d;
   logic              busy_q, busy_d;
`ifdef LOAD_CHECKSUM_EN
   logic              err_q, err_d;
   logic [31:0]       csum_q, csum_d;
`endif

   logic              xfer;
   logic [1:0]        hdr_cmd;
   logic [CNT_W-1:0]  hdr_cnt;
   logic [ADDR_W-1:0] hdr_addr;
   logic [CNT_W-1:0]  done_inc;

   assign s_ready  = (state_q != S_COMMIT);
   assign xfer     = s_valid && s_ready;
   assign hdr_cmd  = s_data[31:30];
   assign hdr_cnt  = s_data[16 +: CNT_W];
   assign hdr_addr = s_data[0 +: ADDR_W];
   assign done_inc = words_done_q + CNT_W'(1);

   always_comb begin
      state_d      = state_q;
      tgt_d        = tgt_q;
      cnt_d        = cnt_q;
      words_done_d = words_done_q;
      inst_addr_d  = inst_addr_q;
      inst_data1_d = inst_data1_q;
      inst_data2_d = inst_data2_q;
      data_addr_d  = data_addr_q;
      data_data1_d = data_data1_q;
      data_data2_d = data_data2_q;
      core_load_d  = core_load_q;
      core_halt_d  = core_halt_q;
      busy_d       = busy_q;
`ifdef LOAD_CHECKSUM_EN
      err_d        = err_q;
      csum_d       = csum_q;
`endif
      case (state_q)
         S_IDLE, S_RUN: begin
            if (xfer) begin
               case (hdr_cmd)
                  CMD_INST, CMD_DATA: begin
                     // Any load header freezes the core, even an empty one.
                     core_load_d = 1'b1;
                     core_halt_d = 1'b1;
                     state_d     = S_IDLE;
                     if (hdr_cnt != '0) begin
                        tgt_d        = hdr_cmd[0];
                        cnt_d        = hdr_cnt;
                        words_done_d = '0;
                        busy_d       = 1'b1;
                        state_d      = S_GET_LO;
                        if (hdr_cmd[0]) data_addr_d = hdr_addr;
                        else            inst_addr_d = hdr_addr;
`ifdef LOAD_CHECKSUM_EN
                        csum_d       = '0;
`endif
                     end
                  end
                  CMD_RUN: begin
                     if (!err) begin
                        core_load_d = 1'b0;
                        core_halt_d = 1'b0;
                        state_d     = S_RUN;
                     end
                  end
                  default: begin
                     // Halt keeps core_load as is so a running pipeline is preserved.
                     core_halt_d = 1'b1;
                     state_d     = S_IDLE;
                  end
               endcase
            end
         end
         S_GET_LO: begin
            if (xfer) begin
               if (tgt_q) data_data1_d = s_data;
               else       inst_data1_d = s_data;
`ifdef LOAD_CHECKSUM_EN
               csum_d  = csum_q ^ s_data;
`endif
               state_d = S_GET_HI;
            end
         end
         S_GET_HI: begin
            if (xfer) begin
               if (tgt_q) data_data2_d = s_data;
               else       inst_data2_d = s_data;
`ifdef LOAD_CHECKSUM_EN
               csum_d  = csum_q ^ s_data;
`endif
               state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            words_done_d = done_inc;
            if (done_inc == cnt_q) begin
`ifdef LOAD_CHECKSUM_EN
               state_d = S_CHECK;
`else
               busy_d  = 1'b0;
               state_d = S_IDLE;
`endif
            end else begin
               if (tgt_q) data_addr_d = data_addr_q + STEP;
               else       inst_addr_d = inst_addr_q + STEP;
               state_d = S_GET_LO;
            end
         end
`ifdef LOAD_CHECKSUM_EN
         S_CHECK: begin
            if (xfer) begin
               if (s_data != csum_q) err_d = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         tgt_q        <= 1'b0;
         cnt_q        <= '0;
         words_done_q <= '0;
         inst_addr_q  <= '0;
         inst_data1_q <= '0;
         inst_data2_q <= '0;
         data_addr_q  <= '0;
         data_data1_q <= '0;
         data_data2_q <= '0;
         core_load_q  <= 1'b1;
         core_halt_q  <= 1'b1;
         busy_q       <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
         err_q        <= 1'b0;
         csum_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         tgt_q        <= tgt_d;
         cnt_q        <= cnt_d;
         words_done_q <= words_done_d;
         inst_addr_q  <= inst_addr_d;
         inst_data1_q <= inst_data1_d;
         inst_data2_q <= inst_data2_d;
         data_addr_q  <= data_addr_d;
         data_data1_q <= data_data1_d;
         data_data2_q <= data_data2_d;
         core_load_q  <= core_load_d;
         core_halt_q  <= core_halt_d;
         busy_q       <= busy_d;
`ifdef LOAD_CHECKSUM_EN
         err_q        <= err_d;
         csum_q       <= csum_d;
`endif
      end
   end

   // Strobes decode straight from the state so they last exactly the COMMIT cycle.
   assign inst_we    = (state_q == S_COMMIT) && !tgt_q;
   assign data_we    = (state_q == S_COMMIT) && tgt_q;
   assign inst_addr  = inst_addr_q;
   assign inst_data1 = inst_data1_q;
   assign inst_data2 = inst_data2_q;
   assign data_addr  = data_addr_q;
   assign data_data1 = data_data1_q;
   assign data_data2 = data_data2_q;
   assign core_load  = core_load_q;
   assign core_halt  = core_halt_q;
   assign busy       = busy_q;
   assign words_done = words_done_q;
`ifdef LOAD_CHECKSUM_EN
   assign err        = err_q;
`else
   assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_load_ctrl.sv
// Scoreboard bench for mem_load_ctrl: stimulus pushes expected commits, a negedge monitor
// pops and compares them; core/err/count status is checked against a session-level model.
`timescale 1ns/1ps
module tb_mem_load_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] s_data = 32'h0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [8:0]  inst_addr, data_addr;
   logic [31:0] inst_data1, inst_data2, data_data1, data_data2;
   logic        inst_we, data_we, core_load, core_halt, busy, err;
   logic [8:0]  words_done;

   mem_load_ctrl #(.ADDR_W(9), .ADDR_STEP(8), .CNT_W(9)) dut (
      .clk(clk), .reset(reset),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .inst_addr(inst_addr), .inst_data1(inst_data1), .inst_data2(inst_data2), .inst_we(inst_we),
      .data_addr(data_addr), .data_data1(data_data1), .data_data2(data_data2), .data_we(data_we),
      .core_load(core_load), .core_halt(core_halt), .busy(busy), .err(err),
      .words_done(words_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        tgt;
      logic [8:0]  addr;
      logic [31:0] d1;
      logic [31:0] d2;
   } commit_t;

   commit_t     exp_q[$];
   commit_t     mon_e;
   int          total = 0;
   int          bad = 0;
   logic        m_load, m_halt, m_err;
   int          m_words;
   logic [8:0]  last_addr [0:1];
   logic [31:0] last_d1 [0:1];
   logic [31:0] last_d2 [0:1];
   int          cyc = 0;
   int          ready_low = 0;
   int          strobe_cyc = 0;
   int          prev_strobe_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Monitor: every commit strobe must match the oldest expected pair; the other bus must hold.
   always @(negedge clk) begin
      if (!s_ready) ready_low++;
      if (inst_we || data_we) begin
         prev_strobe_cyc = strobe_cyc;
         strobe_cyc = cyc;
         check("commit_s_ready", 32'(s_ready), 32'd0);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_strobe: got inst_we=%0b data_we=%0b required none", inst_we, data_we);
         end else begin
            mon_e = exp_q.pop_front();
            check("strobe_sel", 32'({inst_we, data_we}), mon_e.tgt ? 32'd1 : 32'd2);
            if (mon_e.tgt) begin
               check("data_addr", 32'(data_addr), 32'(mon_e.addr));
               check("data_data1", data_data1, mon_e.d1);
               check("data_data2", data_data2, mon_e.d2);
               check("inst_addr_hold", 32'(inst_addr), 32'(last_addr[0]));
               check("inst_data1_hold", inst_data1, last_d1[0]);
               check("inst_data2_hold", inst_data2, last_d2[0]);
            end else begin
               check("inst_addr", 32'(inst_addr), 32'(mon_e.addr));
               check("inst_data1", inst_data1, mon_e.d1);
               check("inst_data2", inst_data2, mon_e.d2);
               check("data_addr_hold", 32'(data_addr), 32'(last_addr[1]));
               check("data_data1_hold", data_data1, last_d1[1]);
               check("data_data2_hold", data_data2, last_d2[1]);
            end
            last_addr[mon_e.tgt] = mon_e.addr;
            last_d1[mon_e.tgt]   = mon_e.d1;
            last_d2[mon_e.tgt]   = mon_e.d2;
         end
      end
   end

   task automatic check_status(input string tag);
      check({tag, "_core_load"}, 32'(core_load), 32'(m_load));
      check({tag, "_core_halt"}, 32'(core_halt), 32'(m_halt));
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_err"}, 32'(err), 32'(m_err));
      check({tag, "_words_done"}, 32'(words_done), 32'(m_words));
   endtask

   // Offer one word after 'gap' idle cycles; returns just after the edge it transferred on.
   task automatic send(input logic [31:0] w, input int gap);
      int guard;
      s_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      s_data  = w;
      s_valid = 1'b1;
      guard   = 0;
      forever begin
         @(negedge clk);
         if (s_ready) begin
            @(posedge clk);
            #1;
            s_valid = 1'b0;
            s_data  = $urandom;
            break;
         end
         guard++;
         if (guard > 50) begin
            total++;
            bad++;
            $display("FAIL send_timeout: s_ready got 0 required 1 within 50 cycles");
            s_valid = 1'b0;
            break;
         end
      end
   endtask

   task automatic do_reset(input int cycles);
      reset   = 1'b1;
      s_valid = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      m_load = 1'b1;
      m_halt = 1'b1;
      m_err  = 1'b0;
      m_words = 0;
      for (int i = 0; i < 2; i++) begin
         last_addr[i] = '0;
         last_d1[i]   = '0;
         last_d2[i]   = '0;
      end
      check_status("reset");
      check("reset_s_ready", 32'(s_ready), 32'd1);
      check("reset_strobes", 32'({inst_we, data_we}), 32'd0);
      check("reset_inst_addr", 32'(inst_addr), 32'd0);
      check("reset_data_addr", 32'(data_addr), 32'd0);
      check("reset_inst_data", inst_data1 | inst_data2, 32'd0);
      check("reset_data_data", data_data1 | data_data2, 32'd0);
   endtask

   task automatic do_load(input logic tgt, input logic [8:0] start, input int n,
                          input int maxgap, input logic junk, input logic bad_sum);
      logic [31:0] hdr, acc, w1, w2;
      logic [8:0]  a;
      int          rl0;
      commit_t     c;
      hdr = {1'b0, tgt, 5'b0, 9'(n), 7'b0, start};
      if (junk) hdr = hdr | ($urandom & 32'h3E00_FE00);
      rl0 = ready_low;
      acc = '0;
      a   = start;
      send(hdr, int'($urandom_range(maxgap, 0)));
      m_load = 1'b1;
      m_halt = 1'b1;
      check("busy_after_hdr", 32'(busy), 32'(n > 0));
      for (int i = 0; i < n; i++) begin
         w1 = $urandom;
         w2 = $urandom;
         c.tgt = tgt;
         c.addr = a;
         c.d1 = w1;
         c.d2 = w2;
         exp_q.push_back(c);
         send(w1, int'($urandom_range(maxgap, 0)));
         send(w2, int'($urandom_range(maxgap, 0)));
         acc = acc ^ w1 ^ w2;
         a = a + 9'd8;
      end
      if (n > 0) m_words = n;
`ifdef LOAD_CHECKSUM_EN
      if (n > 0) begin
         if (bad_sum) begin
            send(acc ^ (32'h1 << $urandom_range(31, 0)), int'($urandom_range(maxgap, 0)));
            m_err = 1'b1;
         end else begin
            send(acc, int'($urandom_range(maxgap, 0)));
         end
      end
`endif
      repeat (2) @(posedge clk);
      #1;
      check_status("load");
      check("ready_low_cycles", 32'(ready_low - rl0), 32'(n));
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("load tgt=%0d start=0x%0h n=%0d bad_sum=%0b words_done=%0d", tgt, start, n, bad_sum, words_done);
   endtask

   task automatic do_cmd(input logic [1:0] cmd, input int gap);
      logic [31:0] hdr;
      hdr = {cmd, 30'b0} | ($urandom & 32'h3FFF_FFFF);
      send(hdr, gap);
      if (cmd == 2'b10 && !m_err) begin
         m_load = 1'b0;
         m_halt = 1'b0;
      end
      if (cmd == 2'b11) m_halt = 1'b1;
      check_status(cmd == 2'b10 ? "run" : "halt");
      $display("cmd %s core_load=%0b core_halt=%0b", cmd == 2'b10 ? "run" : "halt", core_load, core_halt);
   endtask

   task automatic do_partial(input logic tgt, input logic [8:0] start);
      send({1'b0, tgt, 5'b0, 9'd3, 7'b0, start}, 0);
      send($urandom, 0);
      do_reset(1);
      repeat (4) @(posedge clk);
      #1;
      check("partial_no_commit", 32'(exp_q.size()), 32'd0);
      check("partial_strobes", 32'({inst_we, data_we}), 32'd0);
      $display("partial load tgt=%0d aborted by reset", tgt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
`ifdef LOAD_CHECKSUM_EN
      commit_t c;
`endif
      do_reset(3);

      do_load(1'b0, 9'h000, 2, 0, 1'b0, 1'b0);
      check("pair_spacing_cycles", 32'(strobe_cyc - prev_strobe_cyc), 32'd3);
      do_load(1'b1, 9'h010, 1, 0, 1'b0, 1'b0);
      do_load(1'b0, 9'h055, 0, 0, 1'b0, 1'b0);

      do_cmd(2'b10, 0);
      do_cmd(2'b10, 1);
      do_cmd(2'b11, 0);
      do_cmd(2'b11, 0);
      do_cmd(2'b10, 0);
      do_load(1'b1, 9'h1F8, 2, 1, 1'b1, 1'b0);
      do_partial(1'b0, 9'h020);

`ifdef LOAD_CHECKSUM_EN
      do_reset(2);
      send(32'h0001_0000, 0);
      c.tgt = 1'b0; c.addr = 9'd0; c.d1 = 32'h5; c.d2 = 32'h3;
      exp_q.push_back(c);
      send(32'h5, 0);
      send(32'h3, 0);
      send(32'h7, 0);
      m_err = 1'b1;
      m_words = 1;
      repeat (2) @(posedge clk);
      #1;
      check_status("csum_bad");
      do_cmd(2'b10, 0);
      do_reset(2);
      send(32'h0001_0000, 0);
      exp_q.push_back(c);
      send(32'h5, 0);
      send(32'h3, 0);
      send(32'h6, 0);
      m_words = 1;
      repeat (2) @(posedge clk);
      #1;
      check_status("csum_good");
      do_cmd(2'b10, 0);
`endif

      for (int k = 0; k < 40; k++) begin
         r = int'($urandom_range(99, 0));
         if (r < 60)
            do_load(1'($urandom_range(1, 0)), 9'($urandom), int'($urandom_range(4, 1)),
                    int'($urandom_range(2, 0)), 1'b1, ($urandom_range(99, 0) < 15));
         else if (r < 78)
            do_cmd(2'b10, int'($urandom_range(2, 0)));
         else if (r < 93)
            do_cmd(2'b11, int'($urandom_range(2, 0)));
         else
            do_partial(1'($urandom_range(1, 0)), 9'($urandom));
      end

      repeat (5) @(posedge clk);
      #1;
      check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
